nonce_tx_queue: RTL and testbench

Buffers golden nonces from the hashing cores and hands them one at a time to `serial_core` for UART transmission back to the host. It sits directly upstream of `serial_core`: it drives its `word`/`tx_ready` inputs and paces itself on its `tx_busy` output. Nonces that arrive while a word is still being shifted out are queued rather than lost. Duplicates and overflow are handled deterministically.

---
 rtl/nonce_tx_queue.sv | 153 +++++++++++++++
 tb/tb_nonce_tx_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_tx_queue.sv
// Golden-nonce FIFO feeding serial_core: queues nonces, drops duplicates of the
// last accepted nonce, and paces single-cycle tx_ready pulses on tx_busy.
module nonce_tx_queue #(
    parameter int DEPTH        = 8,
    parameter int DEDUP        = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              golden_nonce,
    input  logic                     nonce_valid,
    output logic [31:0]              word,
    output logic                     tx_ready,
    input  logic                     tx_busy,
    input  logic                     clear_overflow,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     last_nonce;
    logic            last_valid;
    logic            full;
    logic            is_dup;
    logic            push;
    logic            drop;
    logic            pop;

    assign full   = (queue_count == FULL_COUNT);
    assign is_dup = (DEDUP != 0) && last_valid && (golden_nonce == last_nonce);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push   = nonce_valid && !is_dup && (!full || pop);
    assign drop   = nonce_valid && !is_dup && full && !pop;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if ((queue_count != '0) && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            tx_ready <= 1'b0;
            word     <= '0;
        end else begin
            state    <= state_next;
            tx_ready <= pop;
            if (pop) begin
                word <= mem[rd_ptr];
            end
            if (state == WAIT_BUSY) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    // NOTE: storage array carries no reset; queue_count alone says which
    // entries are meaningful, and this keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= golden_nonce;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            last_nonce  <= '0;
            last_valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_nonce <= golden_nonce;
                last_valid <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   queue_count <= queue_count + 1'b1;
                2'b01:   queue_count <= queue_count - 1'b1;
                default: queue_count <= queue_count;
            endcase
        end
    end

    // Clear has priority, but a drop in the same cycle is still recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= {7'd0, drop};
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Scoreboard bench for nonce_tx_queue: stimulus pushes expected words, a
// monitor pops and compares on every tx_ready pulse.
module tb_nonce_tx_queue;

    localparam int DEPTH    = 8;
    localparam int BUSY_LEN = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] golden_nonce = '0;
    logic        nonce_valid = 1'b0;
    logic [31:0] word;
    logic        tx_ready;
    logic        tx_busy;
    logic        clear_overflow = 1'b0;
    logic [3:0]  queue_count;
    logic        overflow;
    logic [7:0]  drop_count;

    logic busy_force = 1'b0;
    logic busy_model = 1'b0;
    logic auto_busy = 1'b0;
    logic model_active = 1'b0;
    logic busy_at_edge = 1'b0;
    logic prev_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulse_count = 0;
    int last_pulse_cyc = 0;
    logic [31:0] exp_q[$];

    assign tx_busy = busy_force | busy_model;

    nonce_tx_queue #(.DEPTH(DEPTH), .DEDUP(1), .BUSY_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .golden_nonce   (golden_nonce),
        .nonce_valid    (nonce_valid),
        .word           (word),
        .tx_ready       (tx_ready),
        .tx_busy        (tx_busy),
        .clear_overflow (clear_overflow),
        .queue_count    (queue_count),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= tx_busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && tx_ready) begin
            pulse_count++;
            last_pulse_cyc = cyc;
            check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
            check("busy_low_before_pulse", {31'd0, busy_at_edge}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("word", word, e);
            end
        end
        prev_ready = tx_ready;
    end

    // serial_core model: busy rises the cycle after tx_ready, held BUSY_LEN cycles.
    always begin
        @(negedge clk);
        if (auto_busy && rst_n && tx_ready) begin
            model_active = 1'b1;
            @(negedge clk);
            busy_model = 1'b1;
            repeat (BUSY_LEN) @(negedge clk);
            busy_model   = 1'b0;
            model_active = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_nonce(input logic [31:0] n, input bit accept);
        golden_nonce = n;
        nonce_valid  = 1'b1;
        if (accept) exp_q.push_back(n);
        @(negedge clk);
        nonce_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int stable = 0;
        int n = 0;
        while (stable < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !model_active && !tx_busy && queue_count == 0)
                stable++;
            else
                stable = 0;
        end
        check("drain_within_budget", (stable >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int base;
        int c0;

        // Reset state
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_word", word, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_queue_count", {28'd0, queue_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single nonce: pulse two cycles after the push
        auto_busy = 1'b1;
        base = pulse_count;
        c0 = cyc;
        push_nonce(32'hDEADBEEF, 1'b1);
        check("single_qc_c1", {28'd0, queue_count}, 32'd1);
        check("single_ready_c1", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        check("single_ready_c2", {31'd0, tx_ready}, 32'd1);
        check("single_word_c2", word, 32'hDEADBEEF);
        check("single_qc_c2", {28'd0, queue_count}, 32'd0);
        @(negedge clk);
        check("single_ready_c3", {31'd0, tx_ready}, 32'd0);
        check("single_pulse_cycle", last_pulse_cyc - c0, 32'd2);
        wait_drain(200);
        check("single_pulse_total", pulse_count - base, 32'd1);

        // Burst while serial_core is busy
        do_reset();
        busy_force = 1'b1;
        base = pulse_count;
        push_nonce(32'h1, 1'b1);
        push_nonce(32'h2, 1'b1);
        push_nonce(32'h3, 1'b1);
        check("burst_qc", {28'd0, queue_count}, 32'd3);
        busy_force = 1'b0;
        wait_drain(600);
        check("burst_pulses", pulse_count - base, 32'd3);

        // Overflow, clear, clear-with-drop, saturation
        do_reset();
        busy_force = 1'b1;
        base = pulse_count;
        for (int i = 0; i < 10; i++) push_nonce(32'h100 + i, i < DEPTH);
        check("ovf_qc", {28'd0, queue_count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_drops", {24'd0, drop_count}, 32'd2);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("clr_flag", {31'd0, overflow}, 32'd0);
        check("clr_drops", {24'd0, drop_count}, 32'd0);
        check("clr_qc", {28'd0, queue_count}, 32'd8);
        clear_overflow = 1'b1;
        push_nonce(32'h200, 1'b0);
        clear_overflow = 1'b0;
        check("clr_push_flag", {31'd0, overflow}, 32'd1);
        check("clr_push_drops", {24'd0, drop_count}, 32'd1);
        for (int i = 0; i < 256; i++) push_nonce(32'h1000 + i, 1'b0);
        check("sat_drops", {24'd0, drop_count}, 32'd255);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("clr2_drops", {24'd0, drop_count}, 32'd0);

        // Full queue with a same-cycle pop accepts the push
        busy_force = 1'b0;
        push_nonce(32'hAA, 1'b1);
        check("fullpop_qc", {28'd0, queue_count}, 32'd8);
        check("fullpop_drops", {24'd0, drop_count}, 32'd0);
        check("fullpop_flag", {31'd0, overflow}, 32'd0);
        check("fullpop_ready", {31'd0, tx_ready}, 32'd1);
        wait_drain(1000);
        check("fullpop_pulses", pulse_count - base, 32'd9);

        // Dedup against the last accepted nonce
        do_reset();
        busy_force = 1'b1;
        base = pulse_count;
        push_nonce(32'h55, 1'b1);
        push_nonce(32'h55, 1'b0);
        push_nonce(32'h66, 1'b1);
        push_nonce(32'h55, 1'b1);
        check("dedup_qc", {28'd0, queue_count}, 32'd3);
        check("dedup_drops", {24'd0, drop_count}, 32'd0);
        busy_force = 1'b0;
        wait_drain(600);
        check("dedup_pulses", pulse_count - base, 32'd3);

        // Busy timeout, then asynchronous reset in WAIT_DONE
        do_reset();
        auto_busy = 1'b0;
        base = pulse_count;
        c0 = cyc;
        push_nonce(32'h12345678, 1'b1);
        push_nonce(32'h9ABCDEF0, 1'b1);
        @(negedge clk);
        check("tmo_first_pulse", last_pulse_cyc - c0, 32'd2);
        while (cyc < c0 + 8) @(negedge clk);
        busy_force = 1'b1;
        push_nonce(32'hCAFEF00D, 1'b1);
        check("tmo_second_pulse", last_pulse_cyc - c0, 32'd8);
        check("tmo_pulse_total", pulse_count - base, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_word", word, 32'd0);
        check("arst_qc", {28'd0, queue_count}, 32'd0);
        check("arst_ready", {31'd0, tx_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        busy_force = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_pulse", pulse_count - base, 32'd2);
        auto_busy = 1'b1;
        push_nonce(32'hCAFEF00D, 1'b1);
        wait_drain(200);
        check("arst_new_pulse", pulse_count - base, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
